reg_hazard_scoreboard: RTL
==========================

// Module: reg_hazard_scoreboard
// PURPOSE
//  Decode-stage scoreboard next to the register file. Keeps a pending-write count per architectural register.
//  Tracks writes issued from ID and retired at writeback (the register file's dest/writeEn). Stalls ID when a source
//  register is still awaiting a write. Register 0 is never tracked: it is hardwired to zero in the register file.
// PARAMETERS
//  ADDR_LEN      5   register address width (matches REG_FILE_ADDR_LEN)
//  REG_COUNT     32  number of tracked registers (matches REG_FILE_SIZE)
//  CNT_W         2   pending-counter width; max in-flight writes per register = 2**CNT_W-1
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset, synchronous, active-high
//  id_valid     in   1          ID holds a valid instruction this cycle
//  src1         in   ADDR_LEN   ID source 1 address (same value driven to register file src1)
//  src2         in   ADDR_LEN   ID source 2 address
//  src1_used    in   1          instruction actually reads src1
//  src2_used    in   1          instruction actually reads src2
//  id_wen       in   1          instruction will write a register
//  id_dest      in   ADDR_LEN   destination of the ID instruction
//  wb_wen       in   1          writeback commits this cycle (= register file writeEn)
//  wb_dest      in   ADDR_LEN   writeback destination (= register file dest)
//  flush_wen    in   1          an in-flight writing instruction is squashed this cycle
//  flush_dest   in   ADDR_LEN   destination of the squashed instruction
//  stall        out  1          hold PC/IF/ID, insert bubble into EX (combinational)
//  busy_mask    out  REG_COUNT  bit r = pend[r]!=0; bit 0 always 0 (registered state)
//  ovf_err      out  1          sticky: issue attempted into a saturated counter
//  unf_err      out  1          sticky: wb/flush decrement of a zero counter
// BEHAVIOUR
//  - State: pend[1..REG_COUNT-1], CNT_W bits each. Reset: all pend=0, busy_mask=0, ovf_err=0, unf_err=0.
//  - Reset applies mid-operation too: every counter clears on that edge. stall is 0 in the first cycle after reset.
//  - Events and hit flags (a hit addressed to register 0 is ignored):
//      issue = id_valid & id_wen & ~stall;  inc[r] = issue & (id_dest==r)
//      dec_w[r] = wb_wen & (wb_dest==r);    dec_f[r] = flush_wen & (flush_dest==r)
//  - Next-state update: next = pend + inc - dec_w - dec_f, evaluated per register at posedge.
//      All three may hit one register in the same cycle; they combine arithmetically (net -2..+1).
//  - Saturation: result > 2**CNT_W-1 -> hold at max, set ovf_err. Result < 0 -> clamp to 0, set unf_err.
//      Both flags clear only on rst.
//  - Same-cycle bypass: the register file writes on negedge, so a wb to r is readable by ID in the same cycle.
//      pend_eff[r] = pend[r] - dec_w[r] (floor 0), combinational.
//  - stall = id_valid & ( (src1_used & src1!=0 & pend_eff[src1]!=0)
//                       | (src2_used & src2!=0 & pend_eff[src2]!=0)
//                       | (id_wen & id_dest!=0 & pend[id_dest]==2**CNT_W-1) )
//  - The third stall term is the structural stall. It prevents counter overflow in normal use.
//      ovf_err therefore flags a protocol violation only.
//  - WAW: several writes to one register may be in flight. A source stays stalled until the count reaches 0.
//  - Latency: an issue is visible in busy_mask and stall one cycle later. A wb clears stall in its own cycle.
//  - Self-dependency (src==id_dest, not pending): no stall. The increment takes effect after the edge.
//  - Stalled instruction never increments (issue gated by ~stall); no combinational loop: stall excludes inc.
// CONFIGURATION
//  SCOREBOARD_STATS_EN defined:
//    - Adds output stall_cycles [15:0]. It counts cycles with stall=1 and saturates at 16'hFFFF.
//    - Reset value 0. Synchronous rst clears it.
//  SCOREBOARD_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 rst=1 two cycles, then idle -> busy_mask=0, stall=0, ovf_err=unf_err=0.
//  2 Cycle0: issue id_dest=5. Cycle1: src1=5, src1_used=1.
//    -> busy_mask[5]=1 and stall=1 until the cycle with wb_wen=1, wb_dest=5.
//    -> In that cycle stall=0; next cycle busy_mask[5]=0.
//  3 Issue dest=7 three times, no wb.
//    -> pend[7]=3; a 4th issue to 7 gives stall=1 with no increment and ovf_err stays 0.
//  4 pend[9]=1. In one cycle: issue dest=9 with wb_dest=9 -> pend[9]=1.
//    Next cycle: flush dest=9 with wb dest=9 -> pend[9]=0 with unf_err=1.
//  5 Issue dest=0 and src1=0 with src1_used=1 -> stall=0 and busy_mask[0]=0 throughout.
//  6 pend[3]=2, then rst=1 for one cycle -> busy_mask=0 next cycle.
//    With SCOREBOARD_STATS_EN, stall_cycles=0 after rst and increments once per stalled cycle.

Source files
------------

// File: rtl/reg_hazard_scoreboard.sv
// Decode-stage register hazard scoreboard: a pending-write counter per register drives the ID stall.
// Optional stall-cycle statistics counter enabled by defining SCOREBOARD_STATS_EN.
module reg_hazard_scoreboard #(
  parameter int ADDR_LEN  = 5,
  parameter int REG_COUNT = 32,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [ADDR_LEN-1:0]  src1,
  input  logic [ADDR_LEN-1:0]  src2,
  input  logic                 src1_used,
  input  logic                 src2_used,
  input  logic                 id_wen,
  input  logic [ADDR_LEN-1:0]  id_dest,
  input  logic                 wb_wen,
  input  logic [ADDR_LEN-1:0]  wb_dest,
  input  logic                 flush_wen,
  input  logic [ADDR_LEN-1:0]  flush_dest,
  output logic                 stall,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic                 ovf_err,
  output logic                 unf_err
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic signed [SUM_W-1:0] SUM_MAX  = SUM_W'(2**CNT_W - 1);
  localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;
  localparam logic signed [SUM_W-1:0] SUM_ONE  = SUM_W'(1);

  logic [REG_COUNT-1:0][CNT_W-1:0] pend_q, pend_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic [CNT_W-1:0] cnt_src1, cnt_src2, cnt_dest;
  logic issue;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [SUM_W-1:0] v);
    if (v > SUM_MAX)       return CNT_MAX;
    else if (v < SUM_ZERO) return '0;
    else                   return v[CNT_W-1:0];
  endfunction

  // Lookup sees the same-cycle writeback because the register file writes on negedge.
  always_comb begin
    cnt_src1 = '0;
    cnt_src2 = '0;
    cnt_dest = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (src1 == ADDR_LEN'(r))    cnt_src1 = pend_q[r];
      if (src2 == ADDR_LEN'(r))    cnt_src2 = pend_q[r];
      if (id_dest == ADDR_LEN'(r)) cnt_dest = pend_q[r];
    end
    if (wb_wen && wb_dest == src1 && cnt_src1 != '0) cnt_src1 = cnt_src1 - 1'b1;
    if (wb_wen && wb_dest == src2 && cnt_src2 != '0) cnt_src2 = cnt_src2 - 1'b1;
    stall = id_valid &&
            ((src1_used && src1 != '0 && cnt_src1 != '0) ||
             (src2_used && src2 != '0 && cnt_src2 != '0) ||
             (id_wen && id_dest != '0 && cnt_dest == CNT_MAX));
  end

  assign issue = id_valid && id_wen && !stall;

  always_comb begin
    logic signed [SUM_W-1:0] sum;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    busy_mask = '0;
    for (int r = 1; r < REG_COUNT; r++) begin
      sum = SUM_W'(pend_q[r]);
      if (issue && id_dest == ADDR_LEN'(r))        sum = sum + SUM_ONE;
      if (wb_wen && wb_dest == ADDR_LEN'(r))       sum = sum - SUM_ONE;
      if (flush_wen && flush_dest == ADDR_LEN'(r)) sum = sum - SUM_ONE;
      if (sum > SUM_MAX)  ovf_d = 1'b1;
      if (sum < SUM_ZERO) unf_d = 1'b1;
      pend_d[r] = sat_cnt(sum);
      busy_mask[r] = pend_q[r] != '0;
    end
    pend_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

`ifdef SCOREBOARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != 16'hFFFF) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
